bcd_stopwatch: RTL and testbench

Parametrised mm:ss stopwatch/timer core that counts directly in BCD digits. It counts up or down, has adjust mode, pause toggle and a wrap pulse. It runs entirely on the system clock: the 1 Hz and 2 Hz rates arrive as single-cycle enables from the clock-divider block, not as clocks. It sits between the divider and the seven-segment display driver, and supersedes the earlier single-mode binary stopwatch counter.

---
 rtl/bcd_stopwatch_if.sv | 28 ++
 rtl/bcd_stopwatch.sv | 153 +++++++++++++++
 tb/tb_bcd_stopwatch.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_stopwatch_if.sv
// Control and display bundle of the bcd_stopwatch core: the master drives the
// ticks and buttons, the slave (the core) drives the BCD digits and status.
interface bcd_stopwatch_if;
    logic       tick_norm;
    logic       tick_adj;
    logic       adj;
    logic       sel;
    logic       dir;
    logic       pause_btn;
    logic       lap;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       paused;
    logic       wrap;
    logic       lap_active;

    modport master (
        output tick_norm, tick_adj, adj, sel, dir, pause_btn, lap,
        input  min_tens, min_ones, sec_tens, sec_ones, paused, wrap, lap_active
    );

    modport slave (
        input  tick_norm, tick_adj, adj, sel, dir, pause_btn, lap,
        output min_tens, min_ones, sec_tens, sec_ones, paused, wrap, lap_active
    );
endinterface

// File: rtl/bcd_stopwatch.sv
// mm:ss up/down stopwatch counting directly in BCD digits, with adjust mode,
// pause toggle and wrap pulse. Define STOPWATCH_LAP_EN to add the lap freeze.
module bcd_stopwatch #(
    parameter int unsigned MAX_MIN = 59
) (
    input  logic            clock,
    input  logic            reset,
    bcd_stopwatch_if.slave  sw
);
    localparam logic [3:0] MAX_TENS = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_ONES = 4'(MAX_MIN % 10);

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
        logic       rolled;
    } step_t;

    // One BCD step of a two-digit field bounded by max; rolled flags the full-range wrap.
    function automatic step_t bcd_step(input logic [3:0] tens, input logic [3:0] ones,
                                       input logic [3:0] max_tens, input logic [3:0] max_ones,
                                       input logic down);
        step_t r;
        r.tens   = tens;
        r.ones   = ones;
        r.rolled = 1'b0;
        if (!down) begin
            if (tens == max_tens && ones == max_ones) begin
                r.tens   = 4'd0;
                r.ones   = 4'd0;
                r.rolled = 1'b1;
            end else if (ones == 4'd9) begin
                r.ones = 4'd0;
                r.tens = tens + 4'd1;
            end else begin
                r.ones = ones + 4'd1;
            end
        end else begin
            if (tens == 4'd0 && ones == 4'd0) begin
                r.tens   = max_tens;
                r.ones   = max_ones;
                r.rolled = 1'b1;
            end else if (ones == 4'd0) begin
                r.ones = 4'd9;
                r.tens = tens - 4'd1;
            end else begin
                r.ones = ones - 4'd1;
            end
        end
        return r;
    endfunction

    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [3:0] next_min_tens, next_min_ones, next_sec_tens, next_sec_ones;
    logic       next_wrap;
    logic       pause_q;
    logic       paused;
    logic       wrap;
    step_t      sec_step;
    step_t      min_step;

    always_comb begin
        sec_step = bcd_step(sec_tens, sec_ones, 4'd5, 4'd9, sw.dir);
        min_step = bcd_step(min_tens, min_ones, MAX_TENS, MAX_ONES, sw.dir);
        // NOTE: every output gets a default first so no path can infer a latch.
        next_min_tens = min_tens;
        next_min_ones = min_ones;
        next_sec_tens = sec_tens;
        next_sec_ones = sec_ones;
        next_wrap     = 1'b0;
        if (!sw.adj && sw.tick_norm) begin
            next_sec_tens = sec_step.tens;
            next_sec_ones = sec_step.ones;
            if (sec_step.rolled) begin
                next_min_tens = min_step.tens;
                next_min_ones = min_step.ones;
                next_wrap     = min_step.rolled;
            end
        end else if (sw.adj && sw.tick_adj) begin
            if (sw.sel) begin
                next_sec_tens = sec_step.tens;
                next_sec_ones = sec_step.ones;
            end else begin
                next_min_tens = min_step.tens;
                next_min_ones = min_step.ones;
            end
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        pause_q <= sw.pause_btn;
        if (reset) begin
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            paused   <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            if (sw.pause_btn && !pause_q) paused <= !paused;
            wrap <= 1'b0;
            // Gated by the registered paused, so a same-cycle toggle does not affect this tick.
            if (!paused) begin
                min_tens <= next_min_tens;
                min_ones <= next_min_ones;
                sec_tens <= next_sec_tens;
                sec_ones <= next_sec_ones;
                wrap     <= next_wrap;
            end
        end
    end

    assign sw.paused = paused;
    assign sw.wrap   = wrap;

`ifdef STOPWATCH_LAP_EN
    logic       lap_q;
    logic       lap_active;
    logic       lap_edge;
    logic [3:0] frz_min_tens, frz_min_ones, frz_sec_tens, frz_sec_ones;

    assign lap_edge = sw.lap && !lap_q;

    always_ff @(posedge clock) begin
        lap_q <= sw.lap;
        if (reset) lap_active <= 1'b0;
        else if (lap_edge) lap_active <= !lap_active;
    end

    // NOTE: the frozen copy carries no reset; it is only shown while lap_active is set.
    always_ff @(posedge clock) begin
        if (!reset && lap_edge && !lap_active) begin
            frz_min_tens <= min_tens;
            frz_min_ones <= min_ones;
            frz_sec_tens <= sec_tens;
            frz_sec_ones <= sec_ones;
        end
    end

    assign sw.lap_active = lap_active;
    assign sw.min_tens   = lap_active ? frz_min_tens : min_tens;
    assign sw.min_ones   = lap_active ? frz_min_ones : min_ones;
    assign sw.sec_tens   = lap_active ? frz_sec_tens : sec_tens;
    assign sw.sec_ones   = lap_active ? frz_sec_ones : sec_ones;
`else
    assign sw.lap_active = 1'b0;
    assign sw.min_tens   = min_tens;
    assign sw.min_ones   = min_ones;
    assign sw.sec_tens   = sec_tens;
    assign sw.sec_ones   = sec_ones;
`endif
endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch: two instances (MAX_MIN 59 and 5) driven identically and
// compared every cycle against a model that counts whole seconds with plain arithmetic.
module tb_bcd_stopwatch;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    bcd_stopwatch_if sw0 ();
    bcd_stopwatch_if sw1 ();

    bcd_stopwatch #(.MAX_MIN(59)) dut0 (.clock(clock), .reset(reset), .sw(sw0.slave));
    bcd_stopwatch #(.MAX_MIN(5))  dut1 (.clock(clock), .reset(reset), .sw(sw1.slave));

    // {min_tens, min_ones, sec_tens, sec_ones, paused, wrap, lap_active}
    logic [18:0] obs [2];
    assign obs[0] = {sw0.min_tens, sw0.min_ones, sw0.sec_tens, sw0.sec_ones,
                     sw0.paused, sw0.wrap, sw0.lap_active};
    assign obs[1] = {sw1.min_tens, sw1.min_ones, sw1.sec_tens, sw1.sec_ones,
                     sw1.paused, sw1.wrap, sw1.lap_active};

    int vectors     = 0;
    int miscompares = 0;

    int maxm [2] = '{59, 5};
    int mm   [2];
    int ms   [2];
    int fm   [2];
    int fs   [2];
    bit mp   [2];
    bit mpq  [2];
    bit mw   [2];
    bit mla  [2];
    bit mlq  [2];

    function automatic void mdl_step(int k, bit rst, bit tn, bit ta, bit a, bit s,
                                     bit d, bit pb, bit lp);
        int period, total, om, os;
        om = mm[k];
        os = ms[k];
        if (rst) begin
            mm[k] = 0; ms[k] = 0; mp[k] = 0; mw[k] = 0; mla[k] = 0;
        end else begin
            mw[k] = 0;
            if (!mp[k]) begin
                if (!a && tn) begin
                    period = (maxm[k] + 1) * 60;
                    total  = om * 60 + os;
                    if (!d) begin
                        mw[k] = (total == period - 1);
                        total = (total + 1) % period;
                    end else begin
                        mw[k] = (total == 0);
                        total = (total + period - 1) % period;
                    end
                    mm[k] = total / 60;
                    ms[k] = total % 60;
                end else if (a && ta) begin
                    if (s) ms[k] = (os + (d ? 59 : 1)) % 60;
                    else   mm[k] = (om + (d ? maxm[k] : 1)) % (maxm[k] + 1);
                end
            end
            if (pb && !mpq[k]) mp[k] = !mp[k];
`ifdef STOPWATCH_LAP_EN
            if (lp && !mlq[k]) begin
                if (!mla[k]) begin
                    fm[k] = om; fs[k] = os; mla[k] = 1;
                end else begin
                    mla[k] = 0;
                end
            end
`endif
        end
        mpq[k] = pb;
        mlq[k] = lp;
    endfunction

    function automatic logic [18:0] exp_vec(int k);
        int m, s;
        m = mla[k] ? fm[k] : mm[k];
        s = mla[k] ? fs[k] : ms[k];
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), mp[k], mw[k], mla[k]};
    endfunction

    task automatic apply(input bit rst, input bit tn, input bit ta, input bit a,
                         input bit s, input bit d, input bit pb, input bit lp);
        reset = rst;
        sw0.tick_norm = tn; sw0.tick_adj = ta; sw0.adj = a; sw0.sel = s;
        sw0.dir = d; sw0.pause_btn = pb; sw0.lap = lp;
        sw1.tick_norm = tn; sw1.tick_adj = ta; sw1.adj = a; sw1.sel = s;
        sw1.dir = d; sw1.pause_btn = pb; sw1.lap = lp;
        @(posedge clock);
        for (int k = 0; k < 2; k++) mdl_step(k, rst, tn, ta, a, s, d, pb, lp);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b1, 1'b1, 1'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL reset dut%0d got %h want %h", k, obs[k], exp_vec(k));
                end
            end
        end
        vectors++;
        if (obs[0] !== 19'h0) begin
            miscompares++;
            $display("FAIL reset_zero got %h want %h", obs[0], 19'h0);
        end
    endtask

    task automatic test_count_up();
        int ticks = 0;
        bit tn;
        apply(1'b1, 0, 0, 0, 0, 0, 0, 0);
        for (int it = 0; it < 20000 && ticks < 3600; it++) begin
            tn = ($urandom_range(0, 2) != 0);
            apply(1'b0, tn, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), 0, 0, 0);
            if (tn) ticks++;
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL count_up dut%0d got %h want %h", k, obs[k], exp_vec(k));
                end
            end
            if (tn && ticks == 60) begin
                vectors++;
                if (obs[0][18:3] !== 16'h0100) begin
                    miscompares++;
                    $display("FAIL up_60_ticks got %h want 0100", obs[0][18:3]);
                end
            end
            if (tn && ticks == 360) begin
                vectors++;
                if (obs[1][18:1] !== {16'h0000, 2'b01}) begin
                    miscompares++;
                    $display("FAIL max5_wrap got %h want %h", obs[1][18:1], {16'h0000, 2'b01});
                end
            end
            if (tn && ticks == 3600) begin
                vectors++;
                if (obs[0][18:1] !== {16'h0000, 2'b01}) begin
                    miscompares++;
                    $display("FAIL max59_wrap got %h want %h", obs[0][18:1], {16'h0000, 2'b01});
                end
            end
        end
        apply(1'b0, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (obs[0][1] !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_single_cycle got %b want 0", obs[0][1]);
        end
    endtask

    task automatic test_count_down();
        apply(1'b1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 52; i++) begin
            if (i < 2)       apply(0, 1, 0, 0, 0, 1, 0, 0);
            else if (i < 50) apply(0, 0, 1, 1, 1, 1, 0, 0);
            else if (i < 51) apply(0, 0, 1, 1, 0, 0, 0, 0);
            else             apply(0, 1, 0, 0, 0, 1, 0, 0);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL count_down dut%0d got %h want %h", k, obs[k], exp_vec(k));
                end
            end
            if (i == 0) begin
                vectors++;
                if (obs[0][18:1] !== {16'h5959, 2'b01}) begin
                    miscompares++;
                    $display("FAIL down_wrap got %h want %h", obs[0][18:1], {16'h5959, 2'b01});
                end
            end
            if (i == 1 || i == 50 || i == 51) begin
                vectors++;
                if (obs[0][18:3] !== (i == 1 ? 16'h5958 : (i == 50 ? 16'h0010 : 16'h0009))) begin
                    miscompares++;
                    $display("FAIL down_step%0d got %h", i, obs[0][18:3]);
                end
            end
        end
    endtask

    task automatic test_adjust();
        apply(1'b1, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 1, 1, 1, 1, 0, 0);
        apply(0, 0, 1, 1, 1, 0, 0, 0);
        vectors++;
        if (obs[0][18:1] !== {16'h0000, 2'b00}) begin
            miscompares++;
            $display("FAIL adj_sec_wrap got %h want %h", obs[0][18:1], {16'h0000, 2'b00});
        end
        for (int i = 0; i < 7; i++) apply(0, 0, 1, 1, 1, 0, 0, 0);
        apply(0, 0, 1, 1, 0, 1, 0, 0);
        apply(0, 1, 0, 1, 0, 0, 0, 0);
        apply(0, 0, 1, 1, 0, 0, 0, 0);
        vectors++;
        if (obs[0][18:1] !== {16'h0007, 2'b00}) begin
            miscompares++;
            $display("FAIL adj_min_wrap got %h want %h", obs[0][18:1], {16'h0007, 2'b00});
        end
        for (int i = 0; i < 200; i++) begin
            apply(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL adjust dut%0d got %h want %h", k, obs[k], exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_pause();
        apply(1'b1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            if (i == 0)      apply(0, 1, 0, 0, 0, 0, 1, 0);
            else if (i < 6)  apply(0, 1, 0, 0, 0, 0, 1, 0);
            else if (i == 6) apply(0, 0, 0, 0, 0, 0, 0, 0);
            else if (i == 7) apply(0, 1, 0, 0, 0, 0, 1, 0);
            else if (i == 8) apply(0, 1, 0, 0, 0, 0, 0, 0);
            else if (i < 12) apply(1, 0, 0, 0, 0, 0, 1, 0);
            else             apply(0, 0, 0, 0, 0, 0, 1, 0);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL pause dut%0d got %h want %h", k, obs[k], exp_vec(k));
                end
            end
            if (i == 0 || i == 5 || i == 7 || i == 8 || i == 13) begin
                vectors++;
                if (obs[0][18:2] !== (i == 0 || i == 5 ? {16'h0001, 1'b1} :
                                      i == 7 ? {16'h0001, 1'b0} :
                                      i == 8 ? {16'h0002, 1'b0} : {16'h0000, 1'b0})) begin
                    miscompares++;
                    $display("FAIL pause_step%0d got %h", i, obs[0][18:2]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        apply(1'b1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)  apply(0, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 27; i++) apply(0, 0, 1, 1, 1, 0, 0, 0);
        vectors++;
        if (obs[1][18:3] !== 16'h0327) begin
            miscompares++;
            $display("FAIL setup_0327 got %h want 0327", obs[1][18:3]);
        end
        apply(0, 1, 0, 0, 0, 0, 0, 0);
        apply(1, 1, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (obs[1] !== 19'h0) begin
            miscompares++;
            $display("FAIL reset_mid got %h want 0", obs[1]);
        end
        apply(0, 0, 1, 1, 0, 1, 0, 0);
        apply(0, 0, 1, 1, 1, 1, 0, 0);
        apply(0, 1, 0, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== exp_vec(k)) begin
                miscompares++;
                $display("FAIL wrap_cancel dut%0d got %h want %h", k, obs[k], exp_vec(k));
            end
        end
    endtask

`ifdef STOPWATCH_LAP_EN
    task automatic test_lap();
        apply(1'b1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            if (i < 12)       apply(0, 1, 0, 0, 0, 0, 0, 0);
            else if (i == 12) apply(0, 0, 0, 0, 0, 0, 0, 1);
            else if (i < 18)  apply(0, 1, 0, 0, 0, 0, 0, 1);
            else if (i == 18) apply(0, 0, 0, 0, 0, 0, 0, 0);
            else              apply(0, 0, 0, 0, 0, 0, 0, 1);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL lap dut%0d got %h want %h", k, obs[k], exp_vec(k));
                end
            end
        end
        vectors++;
        if (obs[0] !== {16'h0017, 3'b000}) begin
            miscompares++;
            $display("FAIL lap_release got %h want %h", obs[0], {16'h0017, 3'b000});
        end
    endtask
`else
    task automatic test_lap();
        apply(1'b1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            apply(0, 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL lap_ignored dut%0d got %h want %h", k, obs[k], exp_vec(k));
                end
            end
        end
    endtask
`endif

    task automatic test_random();
        bit pb = 0;
        bit lp = 0;
        apply(1'b1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) pb = !pb;
            if ($urandom_range(0, 7) == 0) lp = !lp;
            apply(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pb, lp);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL random dut%0d got %h want %h", k, obs[k], exp_vec(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_adjust();
        test_pause();
        test_reset_mid();
        test_lap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
